// File: rtl/sprite_dispatcher_if.sv
// Sprite dispatcher bus: table write port plus the sprite valid/ready transfer stream.
// master = dispatcher side, slave = game logic / graphics block side.
interface sprite_dispatcher_if #(
    parameter int MAX_SPRITES   = 16,
    parameter int NUM_FRAMES    = 18,
    parameter int CANVAS_WIDTH  = 360,
    parameter int CANVAS_HEIGHT = 720
);
    localparam int IW = $clog2(MAX_SPRITES);
    localparam int XW = $clog2(CANVAS_WIDTH);
    localparam int YW = $clog2(CANVAS_HEIGHT);
    localparam int FW = $clog2(NUM_FRAMES);

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic          wr_active;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [FW-1:0] wr_frame;

    logic          sprite_valid;
    logic          sprite_ready;
    logic [XW-1:0] sprite_x;
    logic [YW-1:0] sprite_y;
    logic [FW-1:0] sprite_frame_number;

    modport master (
        input  wr_en, wr_idx, wr_active, wr_x, wr_y, wr_frame, sprite_ready,
        output sprite_valid, sprite_x, sprite_y, sprite_frame_number
    );

    modport slave (
        output wr_en, wr_idx, wr_active, wr_x, wr_y, wr_frame, sprite_ready,
        input  sprite_valid, sprite_x, sprite_y, sprite_frame_number
    );
endinterface

// File: rtl/sprite_dispatcher.sv
// Sweeps a sprite register table once per frame_count change, offering each eligible entry in index order.
// Optional SPRITE_CULL_EN: entries whose x/y fall outside the canvas are skipped.
module sprite_dispatcher #(
    parameter int MAX_SPRITES   = 16,
    parameter int NUM_FRAMES    = 18,
    parameter int CANVAS_WIDTH  = 360,
    parameter int CANVAS_HEIGHT = 720
) (
    input  logic                 clk_pixel,
    input  logic                 sys_rst_n,
    input  logic [5:0]           frame_count_i,
    sprite_dispatcher_if.master  bus,
    output logic                 busy_o,
    output logic                 sweep_done_o,
    output logic                 overrun_o
);
    // state    | meaning
    // IDLE     | waiting for a frame event
    // SCAN     | examining table entry idx, one per cycle
    // PRESENT  | offering snapshot of entry idx until accepted
    // HOLDOFF  | one dead cycle while the graphics block drops ready
    localparam int IW = $clog2(MAX_SPRITES);
    localparam int XW = $clog2(CANVAS_WIDTH);
    localparam int YW = $clog2(CANVAS_HEIGHT);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_SPRITES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    logic          act_q   [MAX_SPRITES];
    logic [XW-1:0] x_tab_q [MAX_SPRITES];
    logic [YW-1:0] y_tab_q [MAX_SPRITES];
    logic [FW-1:0] f_tab_q [MAX_SPRITES];

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          restart_q, restart_d;
    logic          valid_q, valid_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [FW-1:0] f_q, f_d;
    logic          done_q, done_d;
    logic [5:0]    prev_q;

    logic frame_event;
    logic last_idx;
    logic eligible;
    logic overrun;

    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                act_q[i]   <= 1'b0;
                x_tab_q[i] <= '0;
                y_tab_q[i] <= '0;
                f_tab_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            act_q[bus.wr_idx]   <= bus.wr_active;
            x_tab_q[bus.wr_idx] <= bus.wr_x;
            y_tab_q[bus.wr_idx] <= bus.wr_y;
            f_tab_q[bus.wr_idx] <= bus.wr_frame;
        end
    end

    assign frame_event = frame_count_i != prev_q;
    assign last_idx    = idx_q == LAST_IDX;

`ifdef SPRITE_CULL_EN
    // One extra bit so a limit that is an exact power of two still compares correctly.
    localparam logic [XW:0] X_LIMIT = (XW+1)'(CANVAS_WIDTH);
    localparam logic [YW:0] Y_LIMIT = (YW+1)'(CANVAS_HEIGHT);
    assign eligible = act_q[idx_q]
                      && ({1'b0, x_tab_q[idx_q]} < X_LIMIT)
                      && ({1'b0, y_tab_q[idx_q]} < Y_LIMIT);
`else
    assign eligible = act_q[idx_q];
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        restart_d = restart_q;
        valid_d   = valid_q;
        x_d       = x_q;
        y_d       = y_q;
        f_d       = f_q;
        done_d    = 1'b0;
        overrun   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_event) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                // Completion wins over a coincident frame event: no overrun, just start again.
                if (!eligible && last_idx) begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = frame_event ? ST_SCAN : ST_IDLE;
                end else if (frame_event) begin
                    overrun = 1'b1;
                    idx_d   = '0;
                end else if (eligible) begin
                    valid_d = 1'b1;
                    x_d     = x_tab_q[idx_q];
                    y_d     = y_tab_q[idx_q];
                    f_d     = f_tab_q[idx_q];
                    state_d = ST_PRESENT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_PRESENT: begin
                if (frame_event) begin
                    overrun   = 1'b1;
                    restart_d = 1'b1;
                end
                if (valid_q && bus.sprite_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (restart_q) begin
                    overrun   = frame_event;
                    restart_d = 1'b0;
                    idx_d     = '0;
                    state_d   = ST_SCAN;
                end else if (last_idx) begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = frame_event ? ST_SCAN : ST_IDLE;
                end else if (frame_event) begin
                    overrun = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            restart_q <= 1'b0;
            valid_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            f_q       <= '0;
            done_q    <= 1'b0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            restart_q <= restart_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            f_q       <= f_d;
            done_q    <= done_d;
            prev_q    <= frame_count_i;
        end
    end

    assign bus.sprite_valid        = valid_q;
    assign bus.sprite_x            = x_q;
    assign bus.sprite_y            = y_q;
    assign bus.sprite_frame_number = f_q;
    assign busy_o                  = state_q != ST_IDLE;
    assign sweep_done_o            = done_q;
    assign overrun_o               = overrun;
endmodule

// File: tb/tb_sprite_dispatcher.sv
// Self-checking bench for sprite_dispatcher: directed scenarios plus randomized tables and ready stalls.
module tb_sprite_dispatcher;
    localparam int MS = 16;

    logic       clk_pixel = 1'b0;
    logic       sys_rst_n;
    logic [5:0] fc;
    logic       busy_o, sweep_done_o, overrun_o;

    sprite_dispatcher_if bus ();

    sprite_dispatcher dut (
        .clk_pixel    (clk_pixel),
        .sys_rst_n    (sys_rst_n),
        .frame_count_i(fc),
        .bus          (bus),
        .busy_o       (busy_o),
        .sweep_done_o (sweep_done_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural table model
    bit m_act [MS];
    int m_x   [MS];
    int m_y   [MS];
    int m_f   [MS];

    typedef struct {int x; int y; int f;} xfer_t;
    xfer_t obs_q[$];
    xfer_t exp_q[$];

    int r_done, r_first, r_min_gap, r_unstable;
    bit r_timeout;

    function automatic bit m_elig(int i);
`ifdef SPRITE_CULL_EN
        return m_act[i] && (m_x[i] < 360) && (m_y[i] < 720);
`else
        return m_act[i];
`endif
    endfunction

    task automatic tick();
        @(posedge clk_pixel);
        @(negedge clk_pixel);
    endtask

    task automatic wr_entry(input int i, input bit a, input int x, input int y, input int f);
        bus.wr_en     = 1'b1;
        bus.wr_idx    = 4'(i);
        bus.wr_active = a;
        bus.wr_x      = 9'(x);
        bus.wr_y      = 10'(y);
        bus.wr_frame  = 5'(f);
        tick();
        bus.wr_en = 1'b0;
        m_act[i] = a; m_x[i] = x; m_y[i] = y; m_f[i] = f;
    endtask

    task automatic clear_table();
        for (int i = 0; i < MS; i++) wr_entry(i, 1'b0, 0, 0, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < MS; i++) begin
            m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_f[i] = 0;
        end
    endtask

    task automatic new_frame();
        fc = fc + 6'd1;
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < MS; i++)
            if (m_elig(i)) exp_q.push_back('{m_x[i], m_y[i], m_f[i]});
    endtask

    // Observes one sweep (called in the event cycle); records transfers, gaps, stalls, done.
    task automatic collect_sweep(input int budget, input int pct);
        bit    pend = 1'b0;
        bit    gap_open = 1'b0;
        int    low = 0;
        xfer_t held;
        obs_q.delete();
        r_done = 0; r_first = -1; r_min_gap = 1000; r_unstable = 0; r_timeout = 1'b1;
        held = '{0, 0, 0};
        for (int k = 1; k <= budget; k++) begin
            tick();
            bus.sprite_ready = ($urandom_range(99) < pct);
            if (pend && (!bus.sprite_valid || int'(bus.sprite_x) != held.x ||
                         int'(bus.sprite_y) != held.y || int'(bus.sprite_frame_number) != held.f))
                r_unstable++;
            pend = 1'b0;
            if (bus.sprite_valid) begin
                if (r_first < 0) r_first = k;
                if (gap_open) begin
                    if (low < r_min_gap) r_min_gap = low;
                    gap_open = 1'b0;
                end
                if (bus.sprite_ready) begin
                    obs_q.push_back('{int'(bus.sprite_x), int'(bus.sprite_y), int'(bus.sprite_frame_number)});
                    gap_open = 1'b1;
                    low = 0;
                end else begin
                    pend = 1'b1;
                    held = '{int'(bus.sprite_x), int'(bus.sprite_y), int'(bus.sprite_frame_number)};
                end
            end else if (gap_open) begin
                low++;
            end
            if (sweep_done_o) begin
                r_done++;
                r_timeout = 1'b0;
                break;
            end
        end
        bus.sprite_ready = 1'b0;
    endtask

    task automatic test_reset();
        int found = -1;
        int saw_valid = 0;
        sys_rst_n = 1'b0;
        fc = 6'd0;
        model_reset();
        repeat (3) tick();
        n_checks++; if (bus.sprite_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.sprite_valid); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy_o); else n_pass++;
        n_checks++; if (sweep_done_o !== 1'b0) $display("FAIL reset_done: got %0b want 0", sweep_done_o); else n_pass++;
        n_checks++; if (overrun_o !== 1'b0) $display("FAIL reset_overrun: got %0b want 0", overrun_o); else n_pass++;
        n_checks++; if (bus.sprite_x !== 9'd0) $display("FAIL reset_x: got %0d want 0", bus.sprite_x); else n_pass++;
        sys_rst_n = 1'b1;
        tick(); tick();
        n_checks++; if (busy_o !== 1'b0) $display("FAIL idle_after_reset_busy: got %0b want 0", busy_o); else n_pass++;
        new_frame();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                n_checks++; if (busy_o !== 1'b1) $display("FAIL busy_at_event_plus1: got %0b want 1", busy_o); else n_pass++;
            end
            if (bus.sprite_valid) saw_valid++;
            if (sweep_done_o) begin found = k; break; end
        end
        n_checks++; if (found != 17) $display("FAIL empty_sweep_done_cycle: got %0d want 17", found); else n_pass++;
        n_checks++; if (saw_valid != 0) $display("FAIL empty_sweep_valid: got %0d valid cycles want 0", saw_valid); else n_pass++;
        tick();
        n_checks++; if (sweep_done_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL done_pulse_width: got done=%0b busy=%0b want 0 0", sweep_done_o, busy_o); else n_pass++;
    endtask

    task automatic test_timing();
        clear_table();
        wr_entry(0, 1'b1, 5, 6, 7);
        wr_entry(1, 1'b1, 8, 9, 10);
        bus.sprite_ready = 1'b1;
        new_frame();
        collect_sweep(200, 100);
        n_checks++; if (r_first != 2) $display("FAIL earliest_valid: got %0d want 2", r_first); else n_pass++;
        n_checks++; if (r_min_gap != 2) $display("FAIL min_offer_gap: got %0d want 2", r_min_gap); else n_pass++;
        n_checks++; if (obs_q.size() != 2) $display("FAIL timing_count: got %0d want 2", obs_q.size()); else n_pass++;
    endtask

    task automatic test_two_sprites();
        clear_table();
        wr_entry(2, 1'b1, 10, 20, 3);
        wr_entry(9, 1'b1, 100, 600, 17);
        build_expected();
        bus.sprite_ready = 1'b1;
        new_frame();
        collect_sweep(300, 100);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL two_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i])
                $display("FAIL two_xfer%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         obs_q[i].x, obs_q[i].y, obs_q[i].f, exp_q[i].x, exp_q[i].y, exp_q[i].f);
            else n_pass++;
        end
        n_checks++; if (r_first != 4) $display("FAIL two_first_valid: got %0d want 4", r_first); else n_pass++;
        n_checks++; if (r_min_gap < 2) $display("FAIL two_gap: got %0d want >=2", r_min_gap); else n_pass++;
        n_checks++; if (r_timeout) $display("FAIL two_done: got timeout want sweep_done"); else n_pass++;
    endtask

    task automatic test_backpressure();
        int waited = -1;
        int bad = 0;
        int extra = 0;
        bit done_seen = 1'b0;
        clear_table();
        wr_entry(4, 1'b1, 77, 333, 11);
        bus.sprite_ready = 1'b0;
        new_frame();
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.sprite_valid) begin waited = k; break; end
        end
        n_checks++; if (waited < 0) $display("FAIL bp_offer: got no valid want valid"); else n_pass++;
        n_checks++; if (int'(bus.sprite_x) != m_x[4] || int'(bus.sprite_y) != m_y[4] || int'(bus.sprite_frame_number) != m_f[4])
            $display("FAIL bp_fields: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", bus.sprite_x, bus.sprite_y,
                     bus.sprite_frame_number, m_x[4], m_y[4], m_f[4]);
        else n_pass++;
        repeat (50) begin
            tick();
            if (!bus.sprite_valid || !busy_o || int'(bus.sprite_x) != m_x[4] ||
                int'(bus.sprite_y) != m_y[4] || int'(bus.sprite_frame_number) != m_f[4]) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); else n_pass++;
        bus.sprite_ready = 1'b1;
        tick();
        n_checks++; if (bus.sprite_valid !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL bp_after_xfer: got valid=%0b busy=%0b want 0 1", bus.sprite_valid, busy_o); else n_pass++;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.sprite_valid) extra++;
            if (sweep_done_o) begin done_seen = 1'b1; break; end
        end
        n_checks++; if (!done_seen || extra != 0)
            $display("FAIL bp_single_xfer: got done=%0b extra_valid=%0d want 1 0", done_seen, extra); else n_pass++;
        bus.sprite_ready = 1'b0;
    endtask

    task automatic test_overrun();
        bit fired = 1'b0;
        bit done_seen = 1'b0;
        clear_table();
        wr_entry(3, 1'b1, 11, 12, 1);
        wr_entry(5, 1'b1, 55, 56, 5);
        wr_entry(7, 1'b1, 77, 78, 7);
        exp_q.delete();
        exp_q.push_back('{11, 12, 1});
        exp_q.push_back('{55, 56, 5});
        exp_q.push_back('{11, 12, 1});
        exp_q.push_back('{55, 56, 5});
        exp_q.push_back('{77, 78, 7});
        obs_q.delete();
        bus.sprite_ready = 1'b1;
        new_frame();
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!fired && bus.sprite_valid && bus.sprite_x == 9'd55) begin
                bus.sprite_ready = 1'b0;
                new_frame();
                #1;
                n_checks++; if (overrun_o !== 1'b1) $display("FAIL overrun_pulse: got %0b want 1", overrun_o); else n_pass++;
                fired = 1'b1;
                tick();
                n_checks++; if (overrun_o !== 1'b0) $display("FAIL overrun_width: got %0b want 0", overrun_o); else n_pass++;
            end
            bus.sprite_ready = 1'b1;
            if (bus.sprite_valid)
                obs_q.push_back('{int'(bus.sprite_x), int'(bus.sprite_y), int'(bus.sprite_frame_number)});
            if (sweep_done_o) begin done_seen = 1'b1; break; end
        end
        bus.sprite_ready = 1'b0;
        n_checks++; if (!done_seen) $display("FAIL overrun_done: got timeout want sweep_done"); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL overrun_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i])
                $display("FAIL overrun_xfer%0d: got x=%0d want x=%0d", i, obs_q[i].x, exp_q[i].x);
            else n_pass++;
        end
    endtask

    task automatic test_write_during_offer();
        int waited = -1;
        bit done_seen = 1'b0;
        clear_table();
        wr_entry(9, 1'b1, 90, 91, 9);
        bus.sprite_ready = 1'b0;
        new_frame();
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.sprite_valid) begin waited = k; break; end
        end
        n_checks++; if (waited < 0) $display("FAIL wr_offer: got no valid want valid"); else n_pass++;
        wr_entry(9, 1'b1, 200, 700, 15);
        tick();
        n_checks++; if (bus.sprite_valid !== 1'b1 || bus.sprite_x != 9'd90 || bus.sprite_y != 10'd91 || bus.sprite_frame_number != 5'd9)
            $display("FAIL wr_snapshot: got (%0d,%0d,%0d) want (90,91,9)", bus.sprite_x, bus.sprite_y, bus.sprite_frame_number);
        else n_pass++;
        bus.sprite_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (sweep_done_o) begin done_seen = 1'b1; break; end
        end
        n_checks++; if (!done_seen) $display("FAIL wr_first_done: got timeout want sweep_done"); else n_pass++;
        build_expected();
        new_frame();
        collect_sweep(300, 100);
        n_checks++; if (obs_q.size() != 1 || obs_q.size() != exp_q.size())
            $display("FAIL wr_next_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else if (obs_q[0] != exp_q[0])
            $display("FAIL wr_next_fields: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", obs_q[0].x, obs_q[0].y, obs_q[0].f,
                     exp_q[0].x, exp_q[0].y, exp_q[0].f);
        else n_pass++;
    endtask

    task automatic test_cull();
        clear_table();
        wr_entry(3, 1'b1, 360, 10, 2);
        wr_entry(6, 1'b1, 359, 719, 4);
        build_expected();
        new_frame();
        collect_sweep(300, 100);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL cull_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i]) $display("FAIL cull_xfer%0d: got x=%0d want x=%0d", i, obs_q[i].x, exp_q[i].x);
            else n_pass++;
        end
    endtask

    task automatic test_done_with_event();
        int found = -1;
        clear_table();
        new_frame();
        repeat (16) tick();
        new_frame();
        #1;
        n_checks++; if (overrun_o !== 1'b0) $display("FAIL done_event_overrun: got %0b want 0", overrun_o); else n_pass++;
        tick();
        n_checks++; if (sweep_done_o !== 1'b1 || busy_o !== 1'b1)
            $display("FAIL done_event_restart: got done=%0b busy=%0b want 1 1", sweep_done_o, busy_o); else n_pass++;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (sweep_done_o) begin found = k; break; end
        end
        n_checks++; if (found != 16) $display("FAIL done_event_second: got %0d want 16", found); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int nw = 4 + $urandom_range(8);
            for (int j = 0; j < nw; j++)
                wr_entry($urandom_range(MS - 1), 1'($urandom_range(1)), $urandom_range(511),
                         $urandom_range(1023), $urandom_range(31));
            build_expected();
            new_frame();
            collect_sweep(3000, 30 + $urandom_range(70));
            n_checks++; if (r_timeout) $display("FAIL rnd%0d_done: got timeout want sweep_done", it); else n_pass++;
            n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd%0d_count: got %0d want %0d", it, obs_q.size(), exp_q.size()); else n_pass++;
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] != exp_q[i])
                    $display("FAIL rnd%0d_xfer%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", it, i,
                             obs_q[i].x, obs_q[i].y, obs_q[i].f, exp_q[i].x, exp_q[i].y, exp_q[i].f);
                else n_pass++;
            end
            n_checks++; if (r_unstable != 0) $display("FAIL rnd%0d_stable: got %0d want 0", it, r_unstable); else n_pass++;
            if (obs_q.size() >= 2) begin
                n_checks++; if (r_min_gap < 2) $display("FAIL rnd%0d_gap: got %0d want >=2", it, r_min_gap); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int waited = -1;
        int vcnt = 0;
        bit done_seen = 1'b0;
        clear_table();
        wr_entry(0, 1'b1, 1, 2, 3);
        wr_entry(1, 1'b1, 4, 5, 6);
        bus.sprite_ready = 1'b0;
        new_frame();
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.sprite_valid) begin waited = k; break; end
        end
        n_checks++; if (waited < 0) $display("FAIL rst_mid_offer: got no valid want valid"); else n_pass++;
        sys_rst_n = 1'b0;
        #1;
        n_checks++; if (bus.sprite_valid !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL rst_mid_drop: got valid=%0b busy=%0b want 0 0", bus.sprite_valid, busy_o); else n_pass++;
        model_reset();
        if (fc == 6'd0) fc = 6'd1;
        tick(); tick();
        sys_rst_n = 1'b1;
        tick();
        n_checks++; if (busy_o !== 1'b1) $display("FAIL rst_prev_cleared: got busy=%0b want 1", busy_o); else n_pass++;
        bus.sprite_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.sprite_valid) vcnt++;
            if (sweep_done_o) begin done_seen = 1'b1; break; end
        end
        n_checks++; if (!done_seen || vcnt != 0)
            $display("FAIL rst_table_cleared: got done=%0b valid_cycles=%0d want 1 0", done_seen, vcnt); else n_pass++;
        bus.sprite_ready = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_active = 1'b0;
        bus.wr_x = '0; bus.wr_y = '0; bus.wr_frame = '0;
        bus.sprite_ready = 1'b0;
        sys_rst_n = 1'b0;
        fc = 6'd0;
        @(negedge clk_pixel);
        test_reset();
        test_timing();
        test_two_sprites();
        test_backpressure();
        test_overrun();
        test_write_during_offer();
        test_cull();
        test_done_with_event();
        test_random();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
